// File: rtl/hack_pkg.sv
// Shared definitions for the HACK program loader: FSM states, framing
// constants and the default idle timeout.
package hack_pkg;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    localparam logic [7:0]  SYNC_BYTE              = 8'hA5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

    // States in which a frame is in progress (busy and timed out).
    function automatic logic is_busy(input state_e s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/hack_timeout.sv
// Idle-clock counter: clears on demand, counts while enabled and flags the
// cycle on which the TIMEOUT_CYCLES-th consecutive idle clock occurs.
module hack_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = hack_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expire on the idle edge that completes the timeout window.
    assign expired = enable && !clear && (cnt_q == LAST);

    // Next count: clear wins, then count up, holding once expired.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hack_loader.sv
// UART program loader: parses a SYNC/LEN/DATA/CSUM frame, writes each word
// into the instruction ROM and releases the CPU only after a good checksum.
module hack_loader
    import hack_pkg::*;
#(
    parameter int          ADDR_W         = 15,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [15:0]       o_rom_data,
    output logic              o_rom_we,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    // Largest word count the ROM can hold.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_data_q, rom_data_d;
    logic              rom_we_q, rom_we_d;
    logic              done_q, done_d;
    logic              busy_q, error_q, cpu_reset_q;
    logic              to_expired;
    logic [15:0]       n_words;

    // Idle timer runs only while a frame is in progress; any byte restarts it.
    hack_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (i_reset_n),
        .clear   (i_rx_valid || !is_busy(state_q)),
        .enable  (is_busy(state_q)),
        .expired (to_expired)
    );

    assign n_words = {len_q[15:8], i_rx_data};

    // Frame parser: next state, checksum, word index and ROM write request.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hi_d       = hi_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        rom_we_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN_HI;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (i_rx_valid) begin
                    len_d[15:8] = i_rx_data;
                    sum_d       = sum_q + i_rx_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (i_rx_valid) begin
                    len_d = n_words;
                    sum_d = sum_q + i_rx_data;
                    if (n_words == 16'd0)
                        state_d = ST_CHECK;
                    else if ({17'd0, n_words} > MAX_WORDS)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (i_rx_valid) begin
                    hi_d    = i_rx_data;
                    sum_d   = sum_q + i_rx_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (i_rx_valid) begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = ADDR_W'(idx_q);
                    rom_data_d = {hi_q, i_rx_data};
                    sum_d      = sum_q + i_rx_data;
                    idx_d      = idx_q + 16'd1;
                    state_d    = (idx_q == len_q - 16'd1) ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == sum_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RUN, ST_ERROR: begin
                // A restart request wins over any byte arriving in the same cycle.
                if (i_start) begin
                    state_d = ST_SYNC;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // The timer only fires on byte-free cycles, so no data action is lost here.
        if (is_busy(state_q) && to_expired)
            state_d = ST_ERROR;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_SYNC;
            len_q       <= '0;
            hi_q        <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            rom_we_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            rom_we_q    <= rom_we_d;
            done_q      <= done_d;
            busy_q      <= is_busy(state_d);
            error_q     <= (state_d == ST_ERROR);
            cpu_reset_q <= (state_d != ST_RUN);
        end
    end

    assign o_rom_addr  = rom_addr_q;
    assign o_rom_data  = rom_data_q;
    assign o_rom_we    = rom_we_q;
    assign o_done      = done_q;
    assign o_busy      = busy_q;
    assign o_error     = error_q;
    assign o_cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_hack_loader.sv
// Self-checking bench for hack_loader: directed frames plus random frames
// compared against a byte-level frame model.
module tb_hack_loader;

    localparam int AW = 4;
    localparam int TO = 16;

    localparam int OUT_IDLE  = 0;
    localparam int OUT_BUSY  = 1;
    localparam int OUT_RUN   = 2;
    localparam int OUT_ERROR = 3;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          i_start;
    logic [AW-1:0] o_rom_addr;
    logic [15:0]   o_rom_data;
    logic          o_rom_we;
    logic          o_cpu_reset;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] words_q[$];
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_out;
    int          exp_done;
    int          obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_done = 0;

    hack_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_start     (i_start),
        .o_rom_addr  (o_rom_addr),
        .o_rom_data  (o_rom_data),
        .o_rom_we    (o_rom_we),
        .o_cpu_reset (o_cpu_reset),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    // Record every ROM write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_rom_we) begin
            obs_addr.push_back(int'(o_rom_addr));
            obs_data.push_back(o_rom_data);
        end
        if (o_done) obs_done++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Idle gap cycles (with occasional ignored restart requests), then one byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            i_start = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        i_start    = 1'b0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    // Frame from words_q: SYNC, big-endian count, words HI/LO, checksum.
    task automatic build_frame(input bit corrupt);
        logic [7:0] s;
        int         n;
        n = words_q.size();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        foreach (words_q[k]) begin
            frame_q.push_back(words_q[k][15:8]);
            frame_q.push_back(words_q[k][7:0]);
        end
        s = 8'd0;
        for (int k = 1; k < frame_q.size(); k++)
            if (k >= frame_q.size() - (3 + 2 * n) + 1) s = 8'(s + frame_q[k]);
        frame_q.push_back(corrupt ? 8'(s + 8'd1) : s);
    endtask

    // Reference: walk the byte stream as the receiver should interpret it.
    task automatic model_frame();
        int         i;
        int         n;
        logic [7:0] sum;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        i = 0;
        sum = 8'd0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        if (i >= frame_q.size()) begin exp_out = OUT_IDLE; return; end
        i++;
        if (i + 2 > frame_q.size()) begin exp_out = OUT_BUSY; return; end
        n = int'({frame_q[i], frame_q[i+1]});
        sum = 8'(frame_q[i] + frame_q[i+1]);
        i += 2;
        if (n > (1 << AW)) begin exp_out = OUT_ERROR; return; end
        for (int w = 0; w < n; w++) begin
            if (i + 2 > frame_q.size()) begin exp_out = OUT_BUSY; return; end
            exp_addr.push_back(w);
            exp_data.push_back({frame_q[i], frame_q[i+1]});
            sum = 8'(sum + frame_q[i] + frame_q[i+1]);
            i += 2;
        end
        if (i >= frame_q.size()) begin exp_out = OUT_BUSY; return; end
        if (frame_q[i] == sum) begin
            exp_out  = OUT_RUN;
            exp_done = 1;
        end else begin
            exp_out = OUT_ERROR;
        end
    endtask

    task automatic check_outcome(input string tag);
        repeat (2) @(negedge clk);
        check({tag, " nwrites"}, obs_addr.size(), exp_addr.size());
        for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
            check($sformatf("%s addr[%0d]", tag, k), obs_addr[k], exp_addr[k]);
            check($sformatf("%s data[%0d]", tag, k), {16'd0, obs_data[k]}, {16'd0, exp_data[k]});
        end
        check({tag, " done"}, obs_done, exp_done);
        check({tag, " error"}, {31'd0, o_error}, {31'd0, exp_out == OUT_ERROR});
        check({tag, " cpu_reset"}, {31'd0, o_cpu_reset}, {31'd0, exp_out != OUT_RUN});
        check({tag, " busy"}, {31'd0, o_busy}, {31'd0, exp_out == OUT_BUSY});
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_done = 0;
    endtask

    task automatic run_frame(input string tag, input int max_gap);
        clear_obs();
        model_frame();
        foreach (frame_q[k]) send_byte(frame_q[k], $urandom_range(0, max_gap));
        check_outcome(tag);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        check({tag, " restart busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, " restart error"}, {31'd0, o_error}, 32'd0);
        check({tag, " restart cpu_reset"}, {31'd0, o_cpu_reset}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_we"}, {31'd0, o_rom_we}, 32'd0);
        check({tag, " rom_addr"}, {28'd0, o_rom_addr}, 32'd0);
        check({tag, " rom_data"}, {16'd0, o_rom_data}, 32'd0);
        check({tag, " cpu_reset"}, {31'd0, o_cpu_reset}, 32'd1);
        check({tag, " busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, " done"}, {31'd0, o_done}, 32'd0);
        check({tag, " error"}, {31'd0, o_error}, 32'd0);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_rx_data  = 8'd0;
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        i_reset_n = 1'b1;
        @(negedge clk);

        // Two-word frame with the correct checksum of its length and data bytes.
        words_q = '{16'h1234, 16'hABCD};
        frame_q.delete();
        build_frame(1'b0);
        run_frame("good2", 0);
        pulse_start("good2");

        // Same frame, checksum off by one: words still land, CPU stays held.
        frame_q.delete();
        build_frame(1'b1);
        run_frame("badsum", 0);
        pulse_start("badsum");

        // Leading noise then an empty frame.
        words_q.delete();
        frame_q = '{8'h00, 8'hFF};
        build_frame(1'b0);
        run_frame("noise_empty", 0);

        // Restart and a SYNC byte in the same cycle: byte must be discarded.
        @(negedge clk);
        i_start    = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hA5;
        @(negedge clk);
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        @(negedge clk);
        check("coincide busy", {31'd0, o_busy}, 32'd0);
        check("coincide cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("coincide_follow", 0);
        pulse_start("coincide");

        // Full ROM (2^AW words) is accepted; one more word is refused.
        words_q.delete();
        for (int k = 0; k < (1 << AW); k++) words_q.push_back(16'($urandom));
        frame_q.delete();
        build_frame(1'b0);
        run_frame("full_rom", 1);
        pulse_start("full_rom");
        frame_q = '{8'hA5, 8'h00, 8'(AW == 4 ? 17 : 0)};
        run_frame("oversize", 0);
        pulse_start("oversize");

        // Random frames with noise, gaps, ignored restarts and bad checksums.
        for (int t = 0; t < 20; t++) begin
            int n;
            frame_q.delete();
            words_q.delete();
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                frame_q.push_back(b == 8'hA5 ? 8'h00 : b);
            end
            n = $urandom_range(0, 17);
            if (n == 17) begin
                frame_q.push_back(8'hA5);
                frame_q.push_back(8'h00);
                frame_q.push_back(8'd17);
            end else begin
                for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
                build_frame($urandom_range(0, 3) == 0);
            end
            run_frame($sformatf("rand%0d", t), 3);
            pulse_start($sformatf("rand%0d", t));
        end

        // Frame stalls after the first data byte: exactly TO idle clocks to ERROR.
        clear_obs();
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
        foreach (frame_q[k]) send_byte(frame_q[k], 0);
        repeat (TO - 1) @(negedge clk);
        check("timeout pre error", {31'd0, o_error}, 32'd0);
        check("timeout pre busy", {31'd0, o_busy}, 32'd1);
        @(negedge clk);
        check("timeout error", {31'd0, o_error}, 32'd1);
        check("timeout busy", {31'd0, o_busy}, 32'd0);
        check("timeout cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
        check("timeout nwrites", obs_addr.size(), 32'd0);
        pulse_start("timeout");

        // Reset between the HI and LO bytes of the second word.
        clear_obs();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        foreach (frame_q[k]) send_byte(frame_q[k], 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        send_byte(8'hCD, 0);
        repeat (3) @(negedge clk);
        check("midreset nwrites", obs_addr.size(), 32'd1);
        check("midreset done", obs_done, 32'd0);
        check("midreset post busy", {31'd0, o_busy}, 32'd0);
        check("midreset post cpu_reset", {31'd0, o_cpu_reset}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
